// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared constants and helpers for handshake units
package handshake_pkg;

    localparam int MODE_INDEXED  = 0;
    localparam int MODE_SEQUENCE = 1;
    localparam int BUF_DEPTH     = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_elastic_buf2.sv
// rtl/handshake_elastic_buf2.sv - 2-slot valid/ready FIFO, ready derived from registered occupancy
module handshake_elastic_buf2
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  w_push;
    logic                  w_pop;

    // Gating with rst keeps the reset cycle free of transfers in both directions.
    assign o_ready = ~rst & (r_cnt != FULL);
    assign o_valid = ~rst & (r_cnt != 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_head <= i_data;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail <= i_data;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/handshake_constant_table_buf.sv
// rtl/handshake_constant_table_buf.sv - table-driven constant source behind a 2-slot elastic buffer
module handshake_constant_table_buf
    import handshake_pkg::*;
#(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_CONSTS = 4,
    parameter int                             IDX_WIDTH  = 2,
    parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONSTS   = '0,
    parameter int                             MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_WIDTH-1:0]  ctrl,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  idx_err
);

    generate
        if (NUM_CONSTS < 1 || IDX_WIDTH < clog2(NUM_CONSTS)) begin : g_bad_params
            $error("handshake_constant_table_buf: NUM_CONSTS must be >=1 and fit in IDX_WIDTH");
        end
    endgenerate

    logic [IDX_WIDTH-1:0]  r_seq;
    logic                  r_idx_err;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic [DATA_WIDTH-1:0] w_value;
    logic                  w_hit;
    logic                  w_accept;

    assign w_accept = ctrl_valid & ctrl_ready;
    assign idx_err  = r_idx_err;

    // Indices with no table entry fall through to zero and leave w_hit low.
    always_comb begin
        w_idx   = (MODE == MODE_SEQUENCE) ? r_seq : ctrl;
        w_value = '0;
        w_hit   = 1'b0;
        for (int i = 0; i < NUM_CONSTS; i++) begin
            if (w_idx == IDX_WIDTH'(i)) begin
                w_value = CONSTS[i*DATA_WIDTH +: DATA_WIDTH];
                w_hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq     <= '0;
            r_idx_err <= 1'b0;
        end else if (w_accept) begin
            if (MODE == MODE_SEQUENCE) begin
                r_seq <= (r_seq == IDX_WIDTH'(NUM_CONSTS - 1)) ? '0 : r_seq + 1'b1;
            end else if (!w_hit) begin
                r_idx_err <= 1'b1;
            end
        end
    end

    handshake_elastic_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_value),
        .i_valid (ctrl_valid),
        .o_ready (ctrl_ready),
        .o_data  (outs),
        .o_valid (outs_valid),
        .i_ready (outs_ready)
    );

endmodule

// File: tb/tb_handshake_constant_table_buf.sv
// tb/tb_handshake_constant_table_buf.sv - directed self-checking bench for handshake_constant_table_buf
module tb_handshake_constant_table_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // sequence-mode instance, entries 10,20,30
    logic [1:0]  s_ctrl = '0;
    logic        s_cv = 1'b0, s_cr, s_ov, s_or = 1'b0, s_err;
    logic [31:0] s_outs;
    // indexed-mode instance, entries 0x111,0x222,0x333
    logic [1:0]  p_ctrl = '0;
    logic        p_cv = 1'b0, p_cr, p_ov, p_or = 1'b0, p_err;
    logic [31:0] p_outs;
    // single-entry sequence instance
    logic [0:0]  u_ctrl = '0;
    logic        u_cv = 1'b0, u_cr, u_ov, u_or = 1'b0, u_err;
    logic [31:0] u_outs;

    handshake_constant_table_buf #(
        .DATA_WIDTH(32), .NUM_CONSTS(3), .IDX_WIDTH(2),
        .CONSTS({32'd30, 32'd20, 32'd10}), .MODE(1)
    ) u_seq (
        .clk(clk), .rst(rst), .ctrl(s_ctrl), .ctrl_valid(s_cv), .ctrl_ready(s_cr),
        .outs(s_outs), .outs_valid(s_ov), .outs_ready(s_or), .idx_err(s_err)
    );

    handshake_constant_table_buf #(
        .DATA_WIDTH(32), .NUM_CONSTS(3), .IDX_WIDTH(2),
        .CONSTS({32'h333, 32'h222, 32'h111}), .MODE(0)
    ) u_idx (
        .clk(clk), .rst(rst), .ctrl(p_ctrl), .ctrl_valid(p_cv), .ctrl_ready(p_cr),
        .outs(p_outs), .outs_valid(p_ov), .outs_ready(p_or), .idx_err(p_err)
    );

    handshake_constant_table_buf #(
        .DATA_WIDTH(32), .NUM_CONSTS(1), .IDX_WIDTH(1),
        .CONSTS(32'h55), .MODE(1)
    ) u_one (
        .clk(clk), .rst(rst), .ctrl(u_ctrl), .ctrl_valid(u_cv), .ctrl_ready(u_cr),
        .outs(u_outs), .outs_valid(u_ov), .outs_ready(u_or), .idx_err(u_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] idx_entry(input int i);
        case (i)
            0:       return 32'h111;
            1:       return 32'h222;
            default: return 32'h333;
        endcase
    endfunction

    logic [31:0] seq_exp [7] = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20, 32'd30, 32'd10};
    logic [31:0] sb_q [$];
    logic [31:0] held;
    logic        stalled;
    int          acc, emi, cyc;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_ready_low", {31'b0, s_cr}, 32'd0);
        chk("rst_valid", {31'b0, s_ov}, 32'd0);
        chk("rst_outs", s_outs, 32'd0);
        chk("rst_idx_err", {31'b0, p_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, s_cr}, 32'd1);

        // sequence mode streaming at full rate
        s_cv = 1'b1; s_or = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("seq_val%0d", k), s_outs, seq_exp[k]);
            chk($sformatf("seq_vld%0d", k), {31'b0, s_ov}, 32'd1);
        end
        s_cv = 1'b0;
        tick();
        chk("seq_drain_vld", {31'b0, s_ov}, 32'd0);
        chk("seq_hold_outs", s_outs, 32'd10);

        // fill sequence buffer to 2 with seq=2, then reset mid-stream
        rst = 1'b1; tick(); rst = 1'b0;
        s_cv = 1'b1; s_or = 1'b0;
        tick(); tick();
        chk("full_ready", {31'b0, s_cr}, 32'd0);
        chk("full_outs", s_outs, 32'd10);
        rst = 1'b1;
        tick();
        chk("midrst_vld", {31'b0, s_ov}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, s_cr}, 32'd1);
        chk("midrst_err", {31'b0, s_err}, 32'd0);
        s_or = 1'b1;
        tick();
        chk("midrst_first", s_outs, 32'd10);
        chk("midrst_first_vld", {31'b0, s_ov}, 32'd1);
        s_cv = 1'b0;
        tick();

        // indexed mode stall: two tokens fill the buffer, head stays stable
        p_ctrl = 2'd2; p_cv = 1'b1; p_or = 1'b0;
        tick();
        chk("stall_c1_ready", {31'b0, p_cr}, 32'd1);
        chk("stall_c1_outs", p_outs, 32'h333);
        p_ctrl = 2'd0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("stall_c%0d_ready", k), {31'b0, p_cr}, 32'd0);
            chk($sformatf("stall_c%0d_outs", k), p_outs, 32'h333);
            chk($sformatf("stall_c%0d_vld", k), {31'b0, p_ov}, 32'd1);
        end
        p_cv = 1'b0; p_or = 1'b1;
        tick();
        chk("drain1_outs", p_outs, 32'h111);
        chk("drain1_ready", {31'b0, p_cr}, 32'd1);
        tick();
        chk("drain2_vld", {31'b0, p_ov}, 32'd0);
        chk("drain2_hold", p_outs, 32'h111);

        // out-of-range index sets the sticky error
        chk("err_before", {31'b0, p_err}, 32'd0);
        p_ctrl = 2'd3; p_cv = 1'b1;
        tick();
        chk("oor_outs", p_outs, 32'd0);
        chk("oor_vld", {31'b0, p_ov}, 32'd1);
        chk("oor_err", {31'b0, p_err}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            p_ctrl = 2'(k % 3);
            tick();
            chk($sformatf("good%0d_outs", k), p_outs, idx_entry(k % 3));
        end
        chk("err_sticky", {31'b0, p_err}, 32'd1);
        p_cv = 1'b0;
        tick();

        // random traffic against a scoreboard
        acc = 0; emi = 0; cyc = 0;
        while ((acc < 300 || sb_q.size() != 0) && cyc < 5000) begin
            p_cv   = (acc < 300) && ($urandom_range(0, 1) == 1);
            p_ctrl = 2'($urandom_range(0, 2));
            p_or   = ($urandom_range(0, 1) == 1);
            #0;
            if (p_cv && p_cr) begin
                sb_q.push_back(idx_entry(int'(p_ctrl)));
                acc++;
            end
            if (p_ov && p_or) begin
                emi++;
                if (sb_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
                else chk("sb_data", p_outs, sb_q.pop_front());
            end
            stalled = p_ov && !p_or;
            held    = p_outs;
            tick();
            cyc++;
            if (stalled) begin
                chk("sb_stall_vld", {31'b0, p_ov}, 32'd1);
                chk("sb_stall_outs", p_outs, held);
            end
        end
        p_cv = 1'b0;
        chk("sb_emitted", emi, 32'd300);
        chk("sb_empty", sb_q.size(), 32'd0);

        // single-entry table
        rst = 1'b1; tick(); rst = 1'b0;
        u_cv = 1'b1; u_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("one%0d_outs", k), u_outs, 32'h55);
            chk($sformatf("one%0d_vld", k), {31'b0, u_ov}, 32'd1);
        end
        chk("one_err", {31'b0, u_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
